// File: rtl/iir_biquad_cascade_pkg.sv
// Shared constants, FSM encodings and the saturating shift used by the biquad cascade.
// Pure definitions; no latency, no backpressure.
package iir_pkg;

    localparam int NCOEF = 5;
    localparam int B0    = 0;
    localparam int B1    = 1;
    localparam int B2    = 2;
    localparam int A1    = 3;
    localparam int A2    = 4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_MAC  = 3'd2;
    localparam state_t ST_WB   = 3'd3;
    localparam state_t ST_OUT  = 3'd4;

    // Arithmetic shift right by cf (floor), then clamp to a signed aw-bit range.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                     input int cf, input int aw);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> cf;
        hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (aw - 1));
        if (sh > hi)      return hi;
        else if (sh < lo) return lo;
        else              return sh;
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Frame handshake, coefficient port and status bundle of the biquad cascade.
// Wires only; no latency, backpressure carried by in_ready.
interface iir_biquad_cascade_if #(
    parameter int AW = 18,
    parameter int CW = 18,
    parameter int S  = 2,
    parameter int CH = 2
);
    localparam int CAW = $clog2(S * 5);

    logic               in_valid;
    logic               in_ready;
    logic [CH*AW-1:0]   in_data;
    logic               out_valid;
    logic [CH*AW-1:0]   out_data;
    logic               coef_we;
    logic [CAW-1:0]     coef_addr;
    logic [CW-1:0]      coef_wdata;
    logic               coef_err;
    logic               clear;
    logic               sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, clear,
        input  in_ready, out_valid, out_data, coef_err, sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, clear,
        output in_ready, out_valid, out_data, coef_err, sat
    );
endinterface

// File: rtl/iir_biquad_cascade_mac.sv
// Shared multiply-accumulate: signed coef x sample added/subtracted into a wide accumulator.
// One product per enabled cycle; o_y/o_clip are combinational views of the accumulator; no backpressure.
module iir_mac
    import iir_pkg::*;
#(
    parameter int AW = 18,
    parameter int CW = 18,
    parameter int CF = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_sub,
    input  logic signed [CW-1:0] i_coef,
    input  logic signed [AW-1:0] i_samp,
    output logic signed [AW-1:0] o_y,
    output logic                 o_clip
);
    localparam int PW   = AW + CW;
    localparam int ACCW = AW + CW + 3;

    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] r_acc;
    logic signed [63:0]     w_acc64;
    logic signed [63:0]     w_sh64;
    logic signed [63:0]     w_sat64;

    assign w_prod     = PW'(i_coef) * PW'(i_samp);
    assign w_prod_ext = ACCW'(w_prod);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
        end
    end

    assign w_acc64 = 64'(r_acc);
    assign w_sh64  = w_acc64 >>> CF;
    assign w_sat64 = sat_trunc(w_acc64, CF, AW);
    assign o_y     = w_sat64[AW-1:0];
    assign o_clip  = (w_sat64 != w_sh64);

endmodule

// File: rtl/iir_biquad_cascade.sv
// CH-channel cascade of S direct-form-I biquads sharing one MAC, with run-time coefficients.
// Latency CH*S*6+2 cycles accept->out_valid; in_ready low from accept until the frame is emitted.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int AW = 18,
    parameter int CW = 18,
    parameter int CF = 16,
    parameter int S  = 2,
    parameter int CH = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    iir_biquad_cascade_if.slave  bus
);
    localparam int NST = CH * S;
    localparam int NCO = S * NCOEF;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW  = (S > 1) ? $clog2(S) : 1;
    localparam int IW  = (NST > 1) ? $clog2(NST) : 1;
    localparam int CAW = $clog2(NCO);

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic [SW-1:0]         r_sec;
    logic [2:0]            r_k;
    logic                  r_rdy;
    logic                  r_out_valid;
    logic [CH*AW-1:0]      r_out_data;
    logic                  r_coef_err;
    logic                  r_sat;
    logic signed [AW-1:0]  r_x;
    logic signed [AW-1:0]  r_in  [CH];
    logic signed [AW-1:0]  r_res [CH];
    logic signed [AW-1:0]  r_x1  [NST];
    logic signed [AW-1:0]  r_x2  [NST];
    logic signed [AW-1:0]  r_y1  [NST];
    logic signed [AW-1:0]  r_y2  [NST];
    logic signed [CW-1:0]  r_coef[NCO];

    logic [IW-1:0]         w_sidx;
    logic [CAW-1:0]        w_cidx;
    logic [CHW-1:0]        w_ch_nxt;
    logic signed [AW-1:0]  w_samp;
    logic signed [AW-1:0]  w_y;
    logic                  w_clip;
    logic                  w_sub;
    logic                  w_coef_ok;
    logic                  w_last_sec;
    logic                  w_last_ch;

    assign w_sidx     = IW'(int'(r_ch) * S + int'(r_sec));
    assign w_cidx     = CAW'(int'(r_sec) * NCOEF + int'(r_k));
    assign w_ch_nxt   = r_ch + CHW'(1);
    assign w_sub      = (r_k >= 3'(A1));
    assign w_last_sec = (int'(r_sec) == S - 1);
    assign w_last_ch  = (int'(r_ch) == CH - 1);
    assign w_coef_ok  = (r_state == ST_IDLE) && (int'(bus.coef_addr) < NCO);

    always_comb begin
        w_samp = r_x;
        case (r_k)
            3'(B1):  w_samp = r_x1[w_sidx];
            3'(B2):  w_samp = r_x2[w_sidx];
            3'(A1):  w_samp = r_y1[w_sidx];
            3'(A2):  w_samp = r_y2[w_sidx];
            default: w_samp = r_x;
        endcase
    end

    iir_mac #(.AW(AW), .CW(CW), .CF(CF)) u_mac (
        .clk    (clk),
        .rst_b  (rst_b),
        .i_clr  ((r_state == ST_LOAD) || (r_state == ST_WB) || bus.clear),
        .i_en   ((r_state == ST_MAC) && !bus.clear),
        .i_sub  (w_sub),
        .i_coef (r_coef[w_cidx]),
        .i_samp (w_samp),
        .o_y    (w_y),
        .o_clip (w_clip)
    );

    // Coefficients survive clear; writes outside IDLE or past the table are rejected.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_coef_err <= 1'b0;
            for (int i = 0; i < NCO; i++)
                r_coef[i] <= (i % NCOEF == B0) ? CW'(1) << CF : '0;
        end else begin
            r_coef_err <= bus.coef_we && !w_coef_ok;
            if (bus.coef_we && w_coef_ok)
                r_coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_rdy       <= 1'b0;
            r_ch        <= '0;
            r_sec       <= '0;
            r_k         <= '0;
            r_x         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int c = 0; c < CH; c++) begin
                r_in[c]  <= '0;
                r_res[c] <= '0;
            end
            for (int i = 0; i < NST; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (bus.clear) begin
                r_state <= ST_IDLE;
                r_rdy   <= 1'b1;
                r_sat   <= 1'b0;
                for (int i = 0; i < NST; i++) begin
                    r_x1[i] <= '0;
                    r_x2[i] <= '0;
                    r_y1[i] <= '0;
                    r_y2[i] <= '0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_rdy <= 1'b1;
                        if (bus.in_valid && r_rdy) begin
                            for (int c = 0; c < CH; c++)
                                r_in[c] <= bus.in_data[c*AW +: AW];
                            r_rdy   <= 1'b0;
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_ch    <= '0;
                        r_sec   <= '0;
                        r_k     <= '0;
                        r_x     <= r_in[0];
                        r_state <= ST_MAC;
                    end
                    ST_MAC: begin
                        r_k <= r_k + 3'd1;
                        if (r_k == 3'(A2)) begin
                            r_k     <= '0;
                            r_state <= ST_WB;
                        end
                    end
                    ST_WB: begin
                        r_x2[w_sidx] <= r_x1[w_sidx];
                        r_x1[w_sidx] <= r_x;
                        r_y2[w_sidx] <= r_y1[w_sidx];
                        r_y1[w_sidx] <= w_y;
                        r_sat        <= r_sat | w_clip;
                        if (w_last_sec) begin
                            r_res[r_ch] <= w_y;
                            r_sec       <= '0;
                            if (w_last_ch) begin
                                r_state <= ST_OUT;
                            end else begin
                                r_ch    <= w_ch_nxt;
                                r_x     <= r_in[w_ch_nxt];
                                r_state <= ST_MAC;
                            end
                        end else begin
                            r_sec   <= r_sec + SW'(1);
                            r_x     <= w_y;
                            r_state <= ST_MAC;
                        end
                    end
                    ST_OUT: begin
                        for (int c = 0; c < CH; c++)
                            r_out_data[c*AW +: AW] <= r_res[c];
                        r_out_valid <= 1'b1;
                        r_rdy       <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = r_rdy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.coef_err  = r_coef_err;
    assign bus.sat       = r_sat;

endmodule
